// File: rtl/sc_speedcounter_backg_pkg.sv
// Shared encodings for the background lane speed counter.
package sc_speedcounter_backg_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COUNT   = 2'd1,
      ST_PENDING = 2'd2
   } state_t;

   localparam logic [1:0] SHIFTSEL_HOLD  = 2'b11;
   localparam logic [1:0] SHIFTSEL_SHIFT = 2'b10;
   localparam logic [1:0] LEVEL_MAX      = 2'd3;

endpackage

// File: rtl/sc_speedcounter_backg_if.sv
// Handshake between the lane FSM (master) and the speed counter (slave).
interface sc_speedcounter_backg_if;

   logic       upcount_InLow;
   logic [1:0] shiftselection_InBus;
   logic       clear_InLow;
   logic       movement_OutLow;
   logic [1:0] level_OutBus;

   modport master (
      output upcount_InLow,
      output shiftselection_InBus,
      output clear_InLow,
      input  movement_OutLow,
      input  level_OutBus
   );

   modport slave (
      input  upcount_InLow,
      input  shiftselection_InBus,
      input  clear_InLow,
      output movement_OutLow,
      output level_OutBus
   );

endinterface

// File: rtl/sc_levelcounter_backg.sv
// Counts acknowledged shifts and steps the speed level every MOVES_PER_LEVEL
// shifts, saturating at LEVEL_MAX.
module sc_levelcounter_backg
   import sc_speedcounter_backg_pkg::*;
#(
   parameter int MOVES_PER_LEVEL = 16
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_inc,
   input  logic       i_clr,
   output logic [1:0] o_level
);

   localparam logic [7:0] MOVES_LAST = 8'(MOVES_PER_LEVEL - 1);

   logic [7:0] r_moves;
   logic [1:0] r_level;

   // Move/level bookkeeping; clear beats increment.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_moves <= '0;
         r_level <= '0;
      end else if (i_clr) begin
         r_moves <= '0;
         r_level <= '0;
      end else if (i_inc) begin
         if (r_moves == MOVES_LAST) begin
            r_moves <= '0;
            if (r_level != LEVEL_MAX)
               r_level <= r_level + 2'd1;
         end else begin
            r_moves <= r_moves + 8'd1;
         end
      end
   end

   assign o_level = r_level;

endmodule

// File: rtl/sc_speedcounter_backg.sv
// Background lane speed counter: counts upcount strobes, raises a movement
// request when the period elapses and holds it until the lane FSM shifts.
// Optional feature macro: SC_SPEEDCOUNTERBACKG_LEVELUP_EN (speed levels).
//
// state      | meaning
// -----------+-------------------------------------------------
// ST_IDLE    | after reset/clear, count held at 0, no request
// ST_COUNT   | counting strobes towards the current period
// ST_PENDING | movement requested, waiting for shift ack
module sc_speedcounter_backg
   import sc_speedcounter_backg_pkg::*;
#(
   parameter int                         DATAWIDTH_COUNT = 24,
   parameter logic [DATAWIDTH_COUNT-1:0] PERIOD_LEVEL0   = 24'd4096,
   parameter int                         MOVES_PER_LEVEL = 16
) (
   input  logic                    SC_SPEEDCOUNTERBACKG_CLOCK_50,
   input  logic                    SC_SPEEDCOUNTERBACKG_RESET_InLow,
   sc_speedcounter_backg_if.slave  bus
);

   state_t                     r_state;
   state_t                     w_state_nxt;
   logic [DATAWIDTH_COUNT-1:0] r_count;
   logic [DATAWIDTH_COUNT-1:0] w_count_nxt;
   logic [DATAWIDTH_COUNT-1:0] w_period;
   logic [DATAWIDTH_COUNT-1:0] w_period_last;
   logic [1:0]                 w_level;
   logic                       w_ack;
   logic                       w_strobe;
   logic                       w_clr;
   logic                       w_movement;

   assign w_ack    = (bus.shiftselection_InBus == SHIFTSEL_SHIFT);
   assign w_strobe = ~bus.upcount_InLow;
   assign w_clr    = ~bus.clear_InLow;

`ifdef SC_SPEEDCOUNTERBACKG_LEVELUP_EN
   logic w_inc;

   // Only an ack that actually retires a pending request counts as a move.
   assign w_inc = (r_state == ST_PENDING) && w_ack && !w_clr;

   sc_levelcounter_backg #(
      .MOVES_PER_LEVEL (MOVES_PER_LEVEL)
   ) u_levelcounter (
      .i_clk   (SC_SPEEDCOUNTERBACKG_CLOCK_50),
      .i_rst_n (SC_SPEEDCOUNTERBACKG_RESET_InLow),
      .i_inc   (w_inc),
      .i_clr   (w_clr),
      .o_level (w_level)
   );

   assign w_period = PERIOD_LEVEL0 >> w_level;
`else
   assign w_level  = 2'd0;
   assign w_period = PERIOD_LEVEL0;
`endif

   assign w_period_last = w_period - DATAWIDTH_COUNT'(1);

   // State and strobe count registers.
   always_ff @(posedge SC_SPEEDCOUNTERBACKG_CLOCK_50 or negedge SC_SPEEDCOUNTERBACKG_RESET_InLow) begin
      if (!SC_SPEEDCOUNTERBACKG_RESET_InLow) begin
         r_state <= ST_IDLE;
         r_count <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_count <= w_count_nxt;
      end
   end

   // Next-state, next-count and state-decoded request output.
   always_comb begin
      w_state_nxt = r_state;
      w_count_nxt = r_count;
      w_movement  = 1'b1;
      if (r_state == ST_PENDING)
         w_movement = 1'b0;
      if (w_clr) begin
         w_state_nxt = ST_IDLE;
         w_count_nxt = '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               w_count_nxt = '0;
               w_state_nxt = ST_COUNT;
            end
            ST_COUNT: begin
               if (w_strobe) begin
                  if (r_count == w_period_last) begin
                     w_count_nxt = '0;
                     w_state_nxt = ST_PENDING;
                  end else begin
                     w_count_nxt = r_count + DATAWIDTH_COUNT'(1);
                  end
               end
            end
            ST_PENDING: begin
               // Strobes are ignored here; the ack alone releases the request.
               if (w_ack)
                  w_state_nxt = ST_COUNT;
            end
            default: begin
               w_state_nxt = ST_IDLE;
               w_count_nxt = '0;
            end
         endcase
      end
   end

   assign bus.movement_OutLow = w_movement;
   assign bus.level_OutBus    = w_level;

endmodule

// File: tb/tb_sc_speedcounter_backg.sv
// Directed bench for sc_speedcounter_backg (PERIOD_LEVEL0=8, MOVES_PER_LEVEL=4).
module tb_sc_speedcounter_backg;
   import sc_speedcounter_backg_pkg::*;

   localparam int P0  = 8;
   localparam int MPL = 4;
`ifdef SC_SPEEDCOUNTERBACKG_LEVELUP_EN
   localparam bit LVL_EN = 1'b1;
`else
   localparam bit LVL_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n;
   sc_speedcounter_backg_if bus();

   sc_speedcounter_backg #(
      .DATAWIDTH_COUNT (24),
      .PERIOD_LEVEL0   (24'd8),
      .MOVES_PER_LEVEL (MPL)
   ) dut (
      .SC_SPEEDCOUNTERBACKG_CLOCK_50    (clk),
      .SC_SPEEDCOUNTERBACKG_RESET_InLow (rst_n),
      .bus                              (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int exp_moves = 0;
   int exp_level = 0;

   function automatic int period();
      return LVL_EN ? (P0 >> exp_level) : P0;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic strobes(input int n);
      for (int i = 0; i < n; i++) begin
         bus.upcount_InLow = 1'b0;
         tick();
      end
      bus.upcount_InLow = 1'b1;
   endtask

   task automatic model_ack();
      if (LVL_EN) begin
         if (exp_moves == MPL - 1) begin
            exp_moves = 0;
            if (exp_level < 3) exp_level++;
         end else begin
            exp_moves++;
         end
      end
   endtask

   task automatic model_clear();
      exp_moves = 0;
      exp_level = 0;
   endtask

   task automatic send_ack();
      bus.shiftselection_InBus = SHIFTSEL_SHIFT;
      tick();
      bus.shiftselection_InBus = SHIFTSEL_HOLD;
      model_ack();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.upcount_InLow = 1'b1;
      bus.shiftselection_InBus = SHIFTSEL_HOLD;
      bus.clear_InLow = 1'b1;
      #12;
      checks++;
      if (bus.movement_OutLow !== 1'b1) begin
         errors++; $display("FAIL reset_movement: got %b want 1", bus.movement_OutLow);
      end
      checks++;
      if (bus.level_OutBus !== 2'd0) begin
         errors++; $display("FAIL reset_level: got %0d want 0", bus.level_OutBus);
      end
      @(negedge clk) rst_n = 1'b1;
      checks++;
      if (dut.r_state !== ST_IDLE) begin
         errors++; $display("FAIL reset_idle: got %0d want %0d", dut.r_state, ST_IDLE);
      end
      tick();
      checks++;
      if (dut.r_state !== ST_COUNT) begin
         errors++; $display("FAIL reset_to_count: got %0d want %0d", dut.r_state, ST_COUNT);
      end
      // Mid-request reset must drop the request without waiting for a clock.
      strobes(P0);
      checks++;
      if (bus.movement_OutLow !== 1'b0) begin
         errors++; $display("FAIL midrun_pending: got %b want 0", bus.movement_OutLow);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (bus.movement_OutLow !== 1'b1) begin
         errors++; $display("FAIL midrun_async_movement: got %b want 1", bus.movement_OutLow);
      end
      checks++;
      if (bus.level_OutBus !== 2'd0) begin
         errors++; $display("FAIL midrun_async_level: got %0d want 0", bus.level_OutBus);
      end
      model_clear();
      @(negedge clk) rst_n = 1'b1;
      checks++;
      if (dut.r_state !== ST_IDLE) begin
         errors++; $display("FAIL midrun_idle: got %0d want %0d", dut.r_state, ST_IDLE);
      end
      tick();
      checks++;
      if (dut.r_state !== ST_COUNT) begin
         errors++; $display("FAIL midrun_to_count: got %0d want %0d", dut.r_state, ST_COUNT);
      end
   endtask

   task automatic test_request();
      strobes(P0 - 1);
      checks++;
      if (bus.movement_OutLow !== 1'b1) begin
         errors++; $display("FAIL req_pre_terminal: got %b want 1", bus.movement_OutLow);
      end
      strobes(1);
      checks++;
      if (bus.movement_OutLow !== 1'b0) begin
         errors++; $display("FAIL req_terminal: got %b want 0", bus.movement_OutLow);
      end
      for (int i = 0; i < 20; i++) begin
         bus.upcount_InLow = (i < 10) ? 1'b1 : 1'b0;
         tick();
         checks++;
         if (bus.movement_OutLow !== 1'b0) begin
            errors++; $display("FAIL req_hold cycle %0d: got %b want 0", i, bus.movement_OutLow);
         end
      end
      bus.upcount_InLow = 1'b1;
   endtask

   task automatic test_ack();
      send_ack();
      checks++;
      if (bus.movement_OutLow !== 1'b1) begin
         errors++; $display("FAIL ack_release: got %b want 1", bus.movement_OutLow);
      end
      strobes(P0 - 1);
      checks++;
      if (bus.movement_OutLow !== 1'b1) begin
         errors++; $display("FAIL ack_recount_pre: got %b want 1", bus.movement_OutLow);
      end
      strobes(1);
      checks++;
      if (bus.movement_OutLow !== 1'b0) begin
         errors++; $display("FAIL ack_recount_terminal: got %b want 0", bus.movement_OutLow);
      end
      send_ack();
      checks++;
      if (bus.level_OutBus !== 2'(exp_level)) begin
         errors++; $display("FAIL ack_level: got %0d want %0d", bus.level_OutBus, exp_level);
      end
   endtask

   task automatic test_level();
      for (int k = 0; k < 14; k++) begin
         strobes(period() - 1);
         checks++;
         if (bus.movement_OutLow !== 1'b1) begin
            errors++; $display("FAIL level_pre move %0d: got %b want 1 (period %0d)", k, bus.movement_OutLow, period());
         end
         strobes(1);
         checks++;
         if (bus.movement_OutLow !== 1'b0) begin
            errors++; $display("FAIL level_terminal move %0d: got %b want 0 (period %0d)", k, bus.movement_OutLow, period());
         end
         send_ack();
         checks++;
         if (bus.level_OutBus !== 2'(exp_level)) begin
            errors++; $display("FAIL level_value move %0d: got %0d want %0d", k, bus.level_OutBus, exp_level);
         end
      end
      checks++;
      if (bus.level_OutBus !== (LVL_EN ? 2'd3 : 2'd0)) begin
         errors++; $display("FAIL level_saturate: got %0d want %0d", bus.level_OutBus, LVL_EN ? 3 : 0);
      end
   endtask

   task automatic test_clear();
      bus.clear_InLow = 1'b0;
      tick();
      model_clear();
      bus.clear_InLow = 1'b1;
      checks++;
      if (bus.level_OutBus !== 2'd0) begin
         errors++; $display("FAIL clear_level0: got %0d want 0", bus.level_OutBus);
      end
      tick();
      for (int k = 0; k < 8; k++) begin
         strobes(period());
         send_ack();
      end
      checks++;
      if (bus.level_OutBus !== (LVL_EN ? 2'd2 : 2'd0)) begin
         errors++; $display("FAIL clear_reach_level2: got %0d want %0d", bus.level_OutBus, LVL_EN ? 2 : 0);
      end
      strobes(period());
      checks++;
      if (bus.movement_OutLow !== 1'b0) begin
         errors++; $display("FAIL clear_pending: got %b want 0", bus.movement_OutLow);
      end
      bus.clear_InLow = 1'b0;
      #1;
      checks++;
      if (bus.movement_OutLow !== 1'b0) begin
         errors++; $display("FAIL clear_sync: got %b want 0 before edge", bus.movement_OutLow);
      end
      tick();
      model_clear();
      checks++;
      if (bus.movement_OutLow !== 1'b1) begin
         errors++; $display("FAIL clear_movement: got %b want 1", bus.movement_OutLow);
      end
      checks++;
      if (bus.level_OutBus !== 2'd0) begin
         errors++; $display("FAIL clear_level: got %0d want 0", bus.level_OutBus);
      end
      bus.clear_InLow = 1'b1;
      tick();
      strobes(P0 - 1);
      checks++;
      if (bus.movement_OutLow !== 1'b1) begin
         errors++; $display("FAIL clear_restart_pre: got %b want 1", bus.movement_OutLow);
      end
      strobes(1);
      checks++;
      if (bus.movement_OutLow !== 1'b0) begin
         errors++; $display("FAIL clear_restart_terminal: got %b want 0", bus.movement_OutLow);
      end
      send_ack();
   endtask

   task automatic test_simultaneous();
      strobes(P0);
      bus.upcount_InLow = 1'b0;
      bus.shiftselection_InBus = SHIFTSEL_SHIFT;
      tick();
      bus.upcount_InLow = 1'b1;
      bus.shiftselection_InBus = SHIFTSEL_HOLD;
      model_ack();
      checks++;
      if (bus.movement_OutLow !== 1'b1) begin
         errors++; $display("FAIL simul_release: got %b want 1", bus.movement_OutLow);
      end
      strobes(period() - 1);
      checks++;
      if (bus.movement_OutLow !== 1'b1) begin
         errors++; $display("FAIL simul_count_pre: got %b want 1", bus.movement_OutLow);
      end
      strobes(1);
      checks++;
      if (bus.movement_OutLow !== 1'b0) begin
         errors++; $display("FAIL simul_count_terminal: got %b want 0", bus.movement_OutLow);
      end
      send_ack();
      // Stray shift select while counting: no move, count continues.
      strobes(3);
      bus.shiftselection_InBus = SHIFTSEL_SHIFT;
      tick();
      bus.shiftselection_InBus = SHIFTSEL_HOLD;
      checks++;
      if (bus.level_OutBus !== 2'(exp_level)) begin
         errors++; $display("FAIL stray_level: got %0d want %0d", bus.level_OutBus, exp_level);
      end
      strobes(period() - 4);
      checks++;
      if (bus.movement_OutLow !== 1'b1) begin
         errors++; $display("FAIL stray_count_pre: got %b want 1", bus.movement_OutLow);
      end
      strobes(1);
      checks++;
      if (bus.movement_OutLow !== 1'b0) begin
         errors++; $display("FAIL stray_count_terminal: got %b want 0", bus.movement_OutLow);
      end
      send_ack();
      checks++;
      if (bus.level_OutBus !== 2'(exp_level)) begin
         errors++; $display("FAIL stray_level_after: got %0d want %0d", bus.level_OutBus, exp_level);
      end
   endtask

   initial begin
      test_reset();
      test_request();
      test_ack();
      test_level();
      test_clear();
      test_simultaneous();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
